// File: rtl/cpu_regfile_if.sv
// Register file access bundle: two combinational read ports and one write port.
// The master drives the addresses and write data; the slave returns read data.
interface cpu_regfile_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output raddr_a, raddr_b, we, waddr, wdata,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  raddr_a, raddr_b, we, waddr, wdata,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/cpu_regfile.sv
// General-purpose register file: 2 async read ports, 1 sync write port.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module cpu_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input logic         clk,
    input logic         rst,
    cpu_regfile_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_en = rf.we && (rf.waddr != '0);
`else
    assign wr_en = rf.we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    // No write bypass: wdata is derived from these outputs upstream.
`ifdef REGFILE_ZERO_REG_EN
    assign rf.rdata_a = (rf.raddr_a == '0) ? '0 : regs[rf.raddr_a];
    assign rf.rdata_b = (rf.raddr_b == '0) ? '0 : regs[rf.raddr_b];
`else
    assign rf.rdata_a = regs[rf.raddr_a];
    assign rf.rdata_b = regs[rf.raddr_b];
`endif
endmodule

// File: tb/tb_cpu_regfile.sv
// Testbench for cpu_regfile: directed scenarios plus randomized traffic
// checked against an array-based model of the register file.
module tb_cpu_regfile;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 2 ** AW;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [DW-1:0] mem [N];

    cpu_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

    cpu_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input int a);
        return (ZERO && a == 0) ? '0 : mem[a];
    endfunction

    task automatic drive(input logic r, input logic w,
                         input int wa, input logic [DW-1:0] wd);
        rst      = r;
        rf.we    = w;
        rf.waddr = AW'(wa);
        rf.wdata = wd;
    endtask

    // One rising edge; the model follows the values the bench is driving.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
        end else if (rf.we && !(ZERO && rf.waddr == 0)) begin
            mem[rf.waddr] = rf.wdata;
        end
        #1;
        rst   = 1'b0;
        rf.we = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input int b);
        rf.raddr_a = AW'(a);
        rf.raddr_b = AW'(b);
        #1;
        chk({tag, "_a"}, rf.rdata_a, mread(a));
        chk({tag, "_b"}, rf.rdata_b, mread(b));
    endtask

    task automatic wr(input int wa, input logic [DW-1:0] wd);
        drive(1'b0, 1'b1, wa, wd);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, '0);
        rf.raddr_a = '0;
        rf.raddr_b = '0;
        for (int i = 0; i < N; i++) mem[i] = 'x;
        tick();

        // reset wins over a simultaneous write
        wr(2, 16'h7777);
        drive(1'b1, 1'b1, 2, 16'hBEEF);
        tick();
        for (int i = 0; i < N; i++) begin
            rd("reset", i, N - 1 - i);
            chk("reset_zero", rf.rdata_a, 16'h0000);
        end

        wr(3, 16'h1234);
        wr(5, 16'hABCD);
        rd("basic", 3, 5);
        chk("basic_r3", rf.rdata_a, 16'h1234);
        chk("basic_r5", rf.rdata_b, 16'hABCD);

        wr(4, 16'h0011);
        drive(1'b0, 1'b1, 4, 16'h00FF);
        rd("nobyp_pre", 4, 4);
        chk("nobyp_old", rf.rdata_a, 16'h0011);
        tick();
        rd("nobyp_post", 4, 4);
        chk("nobyp_new", rf.rdata_a, 16'h00FF);

        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 6, 16'hFFFF);
            tick();
        end
        rd("we_low", 6, 6);
        chk("we_low_r6", rf.rdata_a, 16'h0000);

        for (int i = 0; i < N; i++) wr(i, DW'(16'h1000 + i));
        for (int i = 0; i < N; i++) begin
            rd("sweep", i, N - 1 - i);
            chk("sweep_val", rf.rdata_a,
                (ZERO && i == 0) ? 16'h0000 : DW'(16'h1000 + i));
        end

        drive(1'b1, 1'b0, 0, '0);
        tick();
        for (int i = 0; i < N; i++) rd("midrst", i, (i + 3) % N);
        wr(1, 16'h0042);
        rd("post_rst", 1, 1);
        chk("post_rst_r1", rf.rdata_a, 16'h0042);

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            int a, b;
            a = int'($urandom_range(N - 1));
            b = int'($urandom_range(N - 1));
            drive($urandom_range(39) == 0, 1'($urandom),
                  int'($urandom_range(N - 1)), DW'($urandom));
            rd("rnd_pre", a, b);
            tick();
            rd("rnd_post", a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Multi-ported general-purpose register file for the 2-stage 16-bit CPU core.
- Two asynchronous (combinational) read ports feed ALU operand A, operand B and the branch condition.
- One synchronous write port takes the ALU writeback.
- Sits inside the second (decode/execute) pipeline stage.

Parameters:
- DATA_WIDTH, 16, width of each register and of read/write data.
- ADDR_WIDTH, 3, register index width; register count is 2**ADDR_WIDTH (8 at default).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- raddr_a  input  ADDR_WIDTH  read port A register index.
- rdata_a  output  DATA_WIDTH  read port A data, combinational from raddr_a.
- raddr_b  input  ADDR_WIDTH  read port B register index.
- rdata_b  output  DATA_WIDTH  read port B data, combinational from raddr_b.
- we  input  1  write enable, sampled at rising clk.
- waddr  input  ADDR_WIDTH  write register index.
- wdata  input  DATA_WIDTH  write data.

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Reset: rst is synchronous and active-high, on clock clk. With rst=1 at a rising edge, every register becomes 0.
  - rst has priority over we; a write in the same cycle is discarded.
  - Both read ports therefore output 0 after the reset edge.
  - Reset asserted mid-operation behaves identically: all contents cleared at that edge.
- Read ports:
  - Purely combinational: rdata_x = reg[raddr_x] in the same cycle.
  - Zero clock latency; no enable.
  - Both ports may address the same register simultaneously and both return the same value.
- Write port:
  - If we=1 and rst=0 at a rising edge, reg[waddr] <= wdata.
  - If we=0, no register changes.
  - Write latency is one cycle: the new value is visible on a read port only after the edge.
- Read-during-write, same address:
  - The read port returns the OLD contents until the edge and the new contents after.
  - There is no write-to-read bypass. This is required: the CPU computes wdata combinationally from rdata_a/rdata_b, so a bypass would create a combinational loop.
- Unknown/X on we is not supported. The bench must drive defined values.
- Address width equals the full index range, so no out-of-range addresses exist.
- Simulation-only: no $display output from the block.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Reads of index 0 on either port always return 0.
  - Writes with waddr=0 are silently ignored.
  - Storage for index 0 may be omitted.
- Not defined: register 0 is an ordinary read/write register like all others.

Test Plan:
- Reset: assert rst one cycle with we=1, waddr=2, wdata=16'hBEEF -> after the edge, all 8 registers read 16'h0000 on both ports; reg2 is not written.
- Basic write/read: write 16'h1234 to r3, 16'hABCD to r5 on consecutive cycles; set raddr_a=3, raddr_b=5 -> rdata_a=16'h1234 and rdata_b=16'hABCD in the same cycle the addresses change.
- No bypass: with r4=16'h0011, drive we=1, waddr=4, wdata=16'h00FF, raddr_a=4 -> rdata_a=16'h0011 before the edge, 16'h00FF after.
- we low: drive we=0, waddr=6, wdata=16'hFFFF for several edges -> r6 keeps its prior value (0 after reset).
- Full sweep: write value 16'h1000+i to each ri, i=0..7, then read all pairs (i, 7-i) -> each port returns the matching value.
  - With REGFILE_ZERO_REG_EN defined, index 0 reads 16'h0000 instead.
- Reset mid-operation: after the full sweep, pulse rst for one cycle -> every read returns 0; a subsequent write of 16'h0042 to r1 reads back 16'h0042.
